// File: rtl/voice_scheduler.sv
// voice_scheduler
// Shares one pipelined waveform generator across NUM_VOICES oscillator voices.
// On each sample tick, every voice's phase goes to the generator, one voice per
// cycle. The returned samples are summed, and the mix is offered downstream over
// a valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   sample_tick     sample-rate strobe; dropped (overrun pulse) unless IDLE
//   cfg_we/voice/fcw/en   CPU write into the per-voice shadow config
//   gen_phase       phase to the shared generator (top 15 accumulator bits)
//   gen_wave        signed generator sample, WAVE_LAT cycles after gen_phase
//   sample_out/valid/ready   signed mix handshake to the DAC/PWM stage
//   busy            any state other than IDLE
//   overrun         one-cycle pulse per dropped tick
//
// state  | meaning
// IDLE   | waiting for sample_tick; shadow config copied to live on leaving
// ISSUE  | one voice per cycle to the generator, accumulators advance
// DRAIN  | waiting for the last in-flight generator result
// OUTPUT | mix held on sample_out until sample_ready
module voice_scheduler #(
    parameter  int NUM_VOICES = 4,
    parameter  int ACC_W      = 24,
    parameter  int WAVE_LAT   = 2,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int OUT_W      = 12 + $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic [VW-1:0]           cfg_voice,
    input  logic [ACC_W-1:0]        cfg_fcw,
    input  logic                    cfg_en,
    output logic [14:0]             gen_phase,
    input  logic signed [11:0]      gen_wave,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    busy,
    output logic                    overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    localparam logic [VW-1:0]       LAST_IDX  = VW'(NUM_VOICES - 1);
    // Oldest tag stage; DRAIN ends once only this stage may still hold a tag.
    localparam logic [WAVE_LAT-1:0] EXIT_MASK = WAVE_LAT'(1) << (WAVE_LAT - 1);

    state_t                    state_q, state_d;
    logic [VW-1:0]             idx_q, idx_d;
    logic signed [OUT_W-1:0]   sum_q, sum_d;
    logic signed [OUT_W-1:0]   out_q, out_d;
    logic                      valid_q, valid_d;
    logic [14:0]               phase_q, phase_d;
    logic                      overrun_q, overrun_d;
    logic [ACC_W-1:0]          acc_q   [NUM_VOICES];
    logic [ACC_W-1:0]          acc_d   [NUM_VOICES];
    logic [ACC_W-1:0]          fcw_q   [NUM_VOICES];
    logic [ACC_W-1:0]          fcw_d   [NUM_VOICES];
    logic [ACC_W-1:0]          fcw_s_q [NUM_VOICES];
    logic [ACC_W-1:0]          fcw_s_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     en_q, en_d, en_s_q, en_s_d;
    // Tag pipeline that runs alongside the generator: vld marks an issued slot, ent holds its enable.
    logic [WAVE_LAT-1:0]       vld_q, vld_d, ent_q, ent_d;

    logic                      cfg_ok;
    logic                      capture;
    logic signed [OUT_W-1:0]   wave_ext;

    assign cfg_ok   = 32'(cfg_voice) < NUM_VOICES;
    assign capture  = vld_q[WAVE_LAT-1] && ent_q[WAVE_LAT-1] &&
                      ((state_q == ISSUE) || (state_q == DRAIN));
    assign wave_ext = OUT_W'(gen_wave);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        out_d     = out_q;
        valid_d   = valid_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        fcw_d     = fcw_q;
        en_d      = en_q;
        fcw_s_d   = fcw_s_q;
        en_s_d    = en_s_q;
        overrun_d = sample_tick && (state_q != IDLE);
        vld_d     = vld_q << 1;
        ent_d     = ent_q << 1;

        if (cfg_we && cfg_ok) begin
            fcw_s_d[cfg_voice] = cfg_fcw;
            en_s_d[cfg_voice]  = cfg_en;
        end

        if (capture) begin
            sum_d = sum_q + wave_ext;
        end

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    sum_d   = '0;
                    fcw_d   = fcw_s_q;
                    en_d    = en_s_q;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (!en_s_q[v]) begin
                            acc_d[v] = '0;
                        end
                    end
                end
            end
            ISSUE: begin
                phase_d  = acc_q[idx_q][ACC_W-1 -: 15];
                vld_d[0] = 1'b1;
                ent_d[0] = en_q[idx_q];
                if (en_q[idx_q]) begin
                    acc_d[idx_q] = acc_q[idx_q] + fcw_q[idx_q];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                // sum_d already includes a capture made in this same cycle.
                if ((vld_q & ~EXIT_MASK) == '0) begin
                    state_d = OUTPUT;
                    out_d   = sum_d;
                    valid_d = 1'b1;
                end
            end
            OUTPUT: begin
                if (sample_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sum_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            phase_q   <= '0;
            overrun_q <= 1'b0;
            en_q      <= '0;
            en_s_q    <= '0;
            vld_q     <= '0;
            ent_q     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v]   <= '0;
                fcw_q[v]   <= '0;
                fcw_s_q[v] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            phase_q   <= phase_d;
            overrun_q <= overrun_d;
            en_q      <= en_d;
            en_s_q    <= en_s_d;
            vld_q     <= vld_d;
            ent_q     <= ent_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v]   <= acc_d[v];
                fcw_q[v]   <= fcw_d[v];
                fcw_s_q[v] <= fcw_s_d[v];
            end
        end
    end

    // In ISSUE the phase comes straight from the accumulator so voice i is seen at T+1+i.
    assign gen_phase    = (state_q == ISSUE) ? acc_q[idx_q][ACC_W-1 -: 15] : phase_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexes one shared, pipelined waveform generator (15-bit phase in, signed 12-bit sample out) across NUM_VOICES oscillator voices in the audio path of the RISC-V SoC. Holds one phase accumulator and frequency control word (FCW) per voice, configured by the CPU through an MMIO write port. Once per sample tick it issues each voice's phase to the generator, sums the returned samples, and offers the mix to the DAC/PWM stage over a valid/ready handshake.

## Interface
- NUM_VOICES, 4: voice count, 1..8. The voice index is clog2(NUM_VOICES) bits, minimum 1.
- ACC_W, 24: phase accumulator and FCW width, at least 15. The generator receives acc[ACC_W-1:ACC_W-15].
- WAVE_LAT, 2: generator latency in cycles, from gen_phase to the matching gen_wave, at least 1.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  single-cycle sample-rate strobe
- cfg_we  in  1  configuration write strobe
- cfg_voice  in  clog2(NUM_VOICES)  voice selected by the write
- cfg_fcw  in  ACC_W  frequency control word
- cfg_en  in  1  voice enable
- gen_phase  out  15  phase presented to the shared generator
- gen_wave  in  12  signed generator sample
- sample_out  out  12+clog2(NUM_VOICES)  signed mix (14 bits at default)
- sample_valid  out  1  mix available
- sample_ready  in  1  downstream accepts the mix
- busy  out  1  asserted in any state other than IDLE
- overrun  out  1  single-cycle pulse when a tick is dropped

## Operation
- Configuration
  - A cfg_we write lands in shadow registers fcw_s[v] and en_s[v], in any state. A later write to the same voice overwrites the earlier one.
  - Live registers fcw[v] and en[v] load from the shadows only in the cycle IDLE leaves for ISSUE. A frame therefore always uses one consistent configuration.
  - At that load, any voice whose new en is 0 has its accumulator cleared to 0.
  - A cfg_voice value of NUM_VOICES or above is ignored.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE
  - sample_tick moves the FSM to ISSUE, clears the accumulator sum and sets the issue index to 0.
- ISSUE
  - One voice per cycle: gen_phase is driven from acc[i][ACC_W-1:ACC_W-15], using the pre-increment value.
  - If en[i] is set, acc[i] is updated to acc[i]+fcw[i] modulo 2^ACC_W, so wrap-around is natural.
  - A tag (valid, en[i]) enters a WAVE_LAT-deep shift register.
  - After index NUM_VOICES-1, the FSM moves to DRAIN.
- DRAIN
  - Lasts until the last tag exits the shift register. gen_phase holds its last value.
- Capture, in ISSUE and DRAIN
  - When an exiting tag has valid=1 and en=1, the sign-extended gen_wave is added to the sum.
  - Disabled voices add 0.
  - The sum cannot overflow: 8 × 2047 fits in 15 bits signed.
- OUTPUT
  - sample_out is registered from the sum and sample_valid=1.
  - sample_out and sample_valid stay stable until sample_ready=1. The FSM then returns to IDLE on the cycle after the handshake.
- A sample_tick that arrives in any state other than IDLE is dropped and overrun pulses for 1 cycle. This includes a tick in the same cycle as the OUTPUT handshake.
- Reset
  - Applies mid-frame as well as at start-up: the FSM returns to IDLE and the shift register is flushed.
  - All accumulators, shadow and live FCWs and enables are set to 0, and the sum is cleared.
- Reset values
  - gen_phase=0, sample_out=0, sample_valid=0, busy=0, overrun=0.

## Timing
- Tick sampled in IDLE at cycle T:
  - busy=1 from T+1.
  - gen_phase carries voice i at T+1+i.
  - Voice i's sample is captured at T+1+i+WAVE_LAT.
  - sample_valid=1 at T+NUM_VOICES+WAVE_LAT+1, which is T+7 at the defaults.
- Handshake completes at cycle H, when sample_valid=1 and sample_ready=1:
  - sample_valid=0 and busy=0 at H+1.
  - A tick at H+1 or later is accepted.
- Minimum tick spacing with no overrun is NUM_VOICES+WAVE_LAT+2 cycles, with sample_ready tied high.
- A configuration write at cycle C has no effect on a frame that started at cycle C or earlier.

## Test plan
- Reset, then one tick with no configuration:
  - sample_valid rises exactly 7 cycles after the tick.
  - sample_out=0.
  - gen_phase stays 0.
- Voice 0 at FCW 0x400000, enabled, driving a square-wave model (phase≤16384 gives +2044, otherwise −2044) over 4 frames:
  - gen_phase for voice 0 is 0x0000, 0x2000, 0x4000, 0x6000.
  - sample_out is 2044, 2044, 2044, −2044.
  - The fifth frame wraps back to phase 0.
- All 4 voices enabled at FCW 0 with the same model:
  - sample_out=8176, which is 0x1FF0.
  - Voices 1 and 3 then disabled: the next frame gives 4088.
- sample_ready held low for 10 cycles while ticks arrive every 8 cycles:
  - sample_out stays stable.
  - overrun pulses once per dropped tick.
  - After the ready handshake, the next tick starts a frame normally.
- Configuration write to voice 2 during ISSUE:
  - The current frame uses the old FCW.
  - The next frame uses the new FCW.
  - Disabling voice 2 returns its accumulator to phase 0 when it is re-enabled.
- rst asserted in the middle of DRAIN:
  - All outputs go to their reset values.
  - A subsequent frame's result excludes any captures from before the reset.
